// File: rtl/ram_master_pkg.sv
// Shared types and default widths for the single-port RAM burst master and its helpers.
package ram_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DATA_WITH_DEF = 8;
    localparam int ADDR_WITH_DEF = 8;
    localparam int LEN_WITH_DEF  = 8;

endpackage

// File: rtl/ram_burst_cnt.sv
// Burst address incrementer plus remaining-length down-counter; the address wraps modulo 2^ADDR_W.
module ram_burst_cnt #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              last,
    output logic              zero
);

    logic [LEN_W-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (load) begin
            cur_addr  <= load_addr;
            remaining <= load_len;
        end else if (step && !zero) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    assign zero = (remaining == '0);
    assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/ram_sp_burst_master.sv
// Burst initiator for a single-port synchronous RAM: write/read bursts over a valid/ready command port.
// Optional RAM_MASTER_BOUNDS_ERR_EN rejects bursts that would run past the top of the address space.
module ram_sp_burst_master
    import ram_master_pkg::*;
#(
    parameter int DATA_WITH = DATA_WITH_DEF,
    parameter int ADDR_WITH = ADDR_WITH_DEF,
    parameter int LEN_WITH  = LEN_WITH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_wr,
    input  logic [ADDR_WITH-1:0] cmd_addr,
    input  logic [LEN_WITH-1:0]  cmd_len,
    input  logic [DATA_WITH-1:0] wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [DATA_WITH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_WITH-1:0] ram_addr,
    output logic [DATA_WITH-1:0] ram_q,
    output logic                 ram_we,
    output logic                 ram_oe,
    input  logic [DATA_WITH-1:0] ram_rd_q,
    output state_t               dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never waits on ready, and rd_valid has no backpressure.

    state_t                 state, next_state;
    logic                   cnt_load, cnt_step, cnt_last, cnt_zero;
    logic [ADDR_WITH-1:0]   cur_addr;
    logic                   issue_we, issue_oe, err_now, bounds_err;
    logic                   oe_d1;

    ram_burst_cnt #(
        .ADDR_W (ADDR_WITH),
        .LEN_W  (LEN_WITH)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .step      (cnt_step),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .cur_addr  (cur_addr),
        .last      (cnt_last),
        .zero      (cnt_zero)
    );

`ifdef RAM_MASTER_BOUNDS_ERR_EN
    localparam int SUM_W = ((ADDR_WITH > LEN_WITH) ? ADDR_WITH : LEN_WITH) + 1;
    logic [SUM_W-1:0] cmd_end;
    assign cmd_end    = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign bounds_err = (cmd_end > (SUM_W'(1) << ADDR_WITH));
`else
    assign bounds_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        wr_ready   = 1'b0;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        issue_we   = 1'b0;
        issue_oe   = 1'b0;
        err_now    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_load = 1'b1;
                    if (bounds_err)          err_now    = 1'b1;
                    else if (cmd_len == '0)  next_state = DONE;
                    else if (cmd_wr)         next_state = WRITE;
                    else                     next_state = READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    issue_we = 1'b1;
                    cnt_step = 1'b1;
                    if (cnt_last) next_state = DONE;
                end
            end
            READ: begin
                if (!cnt_zero) begin
                    issue_oe = 1'b1;
                    cnt_step = 1'b1;
                end
                if (cnt_last || cnt_zero) next_state = DRAIN;
            end
            // Once the last issue has retired from ram_oe, its data is being captured this cycle.
            DRAIN:   if (!ram_oe) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we   <= 1'b0;
            ram_oe   <= 1'b0;
            ram_addr <= '0;
            ram_q    <= '0;
            oe_d1    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
        end else begin
            ram_we <= issue_we;
            ram_oe <= issue_oe;
            if (issue_we || issue_oe) ram_addr <= cur_addr;
            if (issue_we)             ram_q    <= wr_data;
            oe_d1    <= ram_oe;
            rd_valid <= oe_d1;
            if (oe_d1) rd_data <= ram_rd_q;
            done <= (state == DONE) || err_now;
        end
    end

`ifdef RAM_MASTER_BOUNDS_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) error <= 1'b0;
        else     error <= err_now;
    end
`else
    assign error = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: doc/ram_sp_burst_master.md
Name: ram_sp_burst_master

Overview:
- Initiator side of the single-port synchronous RAM interface (ports addr / q / rd_q / we / oe).
- Accepts burst commands (direction, base address, length) over a valid/ready handshake.
- Sequences per-word RAM accesses: streams write data in and read data out.
- Sits between a DMA/memcpy-style controller and one single-port RAM instance; the memcpy engine is built on top of it.

Parameters:
- DATA_WITH, 8, RAM word width.
- ADDR_WITH, 8, RAM address width; depth is 1<<ADDR_WITH.
- LEN_WITH, 8, burst length field width, in words.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WITH  burst base address
- cmd_len  in  LEN_WITH  word count; 0 = no-op
- wr_data  in  DATA_WITH  write stream data
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted this cycle
- rd_data  out  DATA_WITH  read stream data
- rd_valid  out  1  rd_data valid; no backpressure
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst end
- error  out  1  one-cycle pulse, only with the optional feature
- ram_addr  out  ADDR_WITH  to RAM addr
- ram_q  out  DATA_WITH  to RAM write data
- ram_we  out  1  to RAM we
- ram_oe  out  1  to RAM oe
- ram_rd_q  in  DATA_WITH  from RAM rd_q

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: all outputs 0 except cmd_ready=1; state=IDLE.
  - ram_we and ram_oe drop immediately on rst, including mid-burst.
  - Any in-flight read data is discarded; no done pulse is produced.
- Output registration: all ram_* outputs and rd_data/rd_valid are registered.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: on cmd_valid, latch cur_addr=cmd_addr and remaining=cmd_len.
  - cmd_len=0 -> DONE.
  - cmd_wr=1 -> WRITE; cmd_wr=0 -> READ.
- WRITE: wr_ready=1.
  - On each wr_valid&&wr_ready, the next cycle has ram_we=1, ram_oe=0, ram_addr=cur_addr, ram_q=wr_data. The RAM stores the word on the edge ending that cycle.
  - Then cur_addr+1 and remaining-1.
  - Gaps in wr_valid produce ram_we=0 cycles.
  - After the handshake that makes remaining 0: wr_ready=0 in the same cycle's next state, state -> DONE.
- READ: one access per cycle.
  - Issue cycle k: ram_oe=1, ram_we=0, ram_addr=cur_addr.
  - ram_rd_q is valid in cycle k+1, which is registered so rd_valid=1 and rd_data are presented in cycle k+2.
  - Fixed latency of 2 cycles from issue to rd_valid; full throughput of 1 word/cycle.
  - After the last issue -> DRAIN.
- DRAIN: ram_oe=0; wait until the last rd_valid is emitted, then -> DONE.
  - ram_rd_q is sampled only in cycles following ram_oe=1. Tri-state / X values at other times are ignored.
- DONE: done=1 for one cycle, -> IDLE.
  - For a write burst, done rises the cycle after the last ram_we.
  - For a read burst, done rises the cycle after the last rd_valid.
- Address arithmetic: modulo 2^ADDR_WITH. Wrap from all-ones to 0 is legal unless the optional feature is enabled.
- Exclusivity: ram_we and ram_oe are never high in the same cycle.
- Commands: accepted only in IDLE; cmd_valid while busy is held off by cmd_ready=0.

Optional Feature:
- Macro: RAM_MASTER_BOUNDS_ERR_EN.
- Defined: in IDLE, when cmd_addr+cmd_len > 2^ADDR_WITH (computed at ADDR_WITH+1 bits), the command is accepted but performs no RAM access.
  - error=1 and done=1 in the same cycle, one cycle after acceptance; then -> IDLE.
- Undefined: addresses wrap silently; the error port is tied 0.

Decomposition:
- Package ram_master_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - default width constants DATA_WITH_DEF=8, ADDR_WITH_DEF=8, LEN_WITH_DEF=8.
- One natural sub-module, ram_burst_cnt: address incrementer plus remaining-length down-counter, with load/step/zero flag. It is shared with the later memcpy engine.

Test Plan:
- Write burst: addr=0x10, len=4, data A0..A3 with wr_valid constant.
  -> ram_we high for 4 consecutive cycles at 0x10..0x13.
  -> done 1 cycle after the last ram_we.
  -> Read-back burst returns A0..A3 with rd_valid 2 cycles after each ram_oe.
- Throttled write: wr_valid toggles every other cycle, len=3.
  -> exactly 3 ram_we pulses, addresses consecutive, ram_we=0 in gaps.
- Wrap: write addr=0xFE, len=4.
  -> accesses at 0xFE, 0xFF, 0x00, 0x01.
  -> With RAM_MASTER_BOUNDS_ERR_EN: no ram_we, error and done pulse together.
- cmd_len=0 read at 0x20.
  -> no ram_oe; done exactly 2 cycles after acceptance (IDLE->DONE->IDLE); rd_valid never high.
- rst asserted mid-read (len=8, after 3 issues).
  -> ram_oe=0 immediately, no further rd_valid, no done, cmd_ready=1.
  -> A new command is accepted on the first cycle after rst deasserts.
- Back-to-back commands: cmd_valid held high with two read commands.
  -> second accepted only after done, cmd_ready=0 throughout busy, ram_we/ram_oe never both high.
